// File: rtl/vdq_pkg.sv
// Shared types and helpers for valid_data_queue and its storage.
package vdq_pkg;

  localparam int unsigned VDQ_MIN_DEPTH  = 2;
  // Upper bound on address width; pointers keep unused high bits at zero.
  localparam int unsigned VDQ_MAX_ADDR_W = 16;

  function automatic int unsigned vdq_addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  typedef struct packed {
    logic                      wrap;
    logic [VDQ_MAX_ADDR_W-1:0] addr;
  } vdq_ptr_t;

endpackage

// File: rtl/vdq_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
// Storage is deliberately not reset.
module vdq_mem #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/valid_data_queue.sv
// DEPTH-entry valid/ready queue with flush, occupancy count and sticky overflow flag.
// Define VDQ_BYPASS_EN to pass data_in straight to data_out while the queue is empty.
module valid_data_queue
  import vdq_pkg::*;
#(
  parameter int unsigned             BIT_OF_DATA = 8,
  parameter logic [BIT_OF_DATA-1:0]  DEF_VALUE   = '0,
  parameter int unsigned             DEPTH       = 4,
  parameter int unsigned             ADDR_W      = vdq_addr_w(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BIT_OF_DATA-1:0] data_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BIT_OF_DATA-1:0] data_out,
  output logic [ADDR_W:0]        count,
  output logic                   ovf_err
);

  if (DEPTH < VDQ_MIN_DEPTH || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("valid_data_queue: DEPTH must be a power of 2 and at least 2");
  end

  vdq_ptr_t wr_q, wr_d, rd_q, rd_d;
  logic [ADDR_W:0] count_q, count_d;
  logic ovf_q, ovf_d;
  logic empty, full, push, pop, bypass_take;
  logic [BIT_OF_DATA-1:0] mem_rdata;

  function automatic vdq_ptr_t ptr_inc(input vdq_ptr_t p);
    vdq_ptr_t n;
    n = p;
    if (p.addr == VDQ_MAX_ADDR_W'(DEPTH - 1)) begin
      n.addr = '0;
      n.wrap = ~p.wrap;
    end else begin
      n.addr = p.addr + 1'b1;
    end
    return n;
  endfunction

  assign empty    = (wr_q == rd_q);
  assign full     = (wr_q.addr == rd_q.addr) && (wr_q.wrap != rd_q.wrap);
  assign in_ready = ~full;

`ifdef VDQ_BYPASS_EN
  // An empty queue forwards the producer word; if it is taken now it never lands in storage.
  assign bypass_take = empty & in_valid & out_ready;
  assign out_valid   = ~empty | in_valid;
  assign data_out    = !empty  ? mem_rdata :
                       in_valid ? data_in  : DEF_VALUE;
`else
  assign bypass_take = 1'b0;
  assign out_valid   = ~empty;
  assign data_out    = empty ? DEF_VALUE : mem_rdata;
`endif

  assign push = in_valid & in_ready & ~bypass_take;
  assign pop  = ~empty & out_ready;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    ovf_d = ovf_q | (in_valid & ~in_ready);
    if (clr) begin
      wr_d  = '0;
      rd_d  = '0;
      ovf_d = 1'b0;
    end else begin
      if (push) wr_d = ptr_inc(wr_q);
      if (pop)  rd_d = ptr_inc(rd_q);
    end
    count_d = {wr_d.wrap, wr_d.addr[ADDR_W-1:0]} - {rd_d.wrap, rd_d.addr[ADDR_W-1:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count   = count_q;
  assign ovf_err = ovf_q;

  vdq_mem #(
    .DEPTH  (DEPTH),
    .WIDTH  (BIT_OF_DATA),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push & ~clr),
    .waddr (wr_q.addr[ADDR_W-1:0]),
    .wdata (data_in),
    .raddr (rd_q.addr[ADDR_W-1:0]),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_valid_data_queue.sv
// Self-checking bench for valid_data_queue: queue-based model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_valid_data_queue;

  localparam int unsigned W     = 8;
  localparam int unsigned DEPTH = 4;
  localparam logic [W-1:0] DEF  = 8'h5A;
`ifdef VDQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [W-1:0] data_in = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [W-1:0] data_out;
  logic [2:0] count;
  logic ovf_err;

  int errors = 0;
  int checks = 0;

  valid_data_queue #(
    .BIT_OF_DATA (W),
    .DEF_VALUE   (DEF),
    .DEPTH       (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .count     (count),
    .ovf_err   (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a plain FIFO of words plus the sticky flag.
  logic [W-1:0] mq[$];
  bit m_ovf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    bit was_empty, was_full, take;
    if (!rst_n) begin
      mq.delete();
      m_ovf <= 1'b0;
    end else if (clr) begin
      mq.delete();
      m_ovf <= 1'b0;
    end else begin
      was_empty = (mq.size() == 0);
      was_full  = (mq.size() == DEPTH);
      take      = BYP && was_empty && in_valid && out_ready;
      if (in_valid && was_full) m_ovf <= 1'b1;
      if (!was_empty && out_ready) void'(mq.pop_front());
      if (in_valid && !was_full && !take) mq.push_back(data_in);
    end
  end

  always @(negedge clk) begin
    logic [W-1:0] e_data;
    logic e_valid;
    e_valid = (mq.size() > 0) || (BYP && in_valid);
    e_data  = (mq.size() > 0) ? mq[0] : ((BYP && in_valid) ? data_in : DEF);
    chk("model out_valid", 32'(out_valid), 32'(e_valid));
    if (e_valid) chk("model data_out", 32'(data_out), 32'(e_data));
    else         chk("model data_out idle", 32'(data_out), 32'(DEF));
    chk("model in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    chk("model count", 32'(count), 32'(mq.size()));
    chk("model ovf_err", 32'(ovf_err), 32'(m_ovf));
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [W-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      in_valid  = 1'b1;
      data_in   = base + W'(i);
      out_ready = 1'b0;
    end
    next_cycle();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] exp_seq [4];
    exp_seq[0] = 8'h11; exp_seq[1] = 8'h22; exp_seq[2] = 8'h33; exp_seq[3] = 8'h44;

    // 1: reset and idle
    #12 rst_n = 1'b1;
    @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 32'h0);
    chk("reset in_ready", 32'(in_ready), 32'h1);
    chk("reset count", 32'(count), 32'h0);
    chk("reset data_out", 32'(data_out), 32'h5A);

    // 2: fill to full, then drain in order
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      in_valid = 1'b1;
      data_in  = exp_seq[i];
    end
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    chk("full count", 32'(count), 32'h4);
    chk("full in_ready", 32'(in_ready), 32'h0);
    next_cycle();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drain data_out", 32'(data_out), 32'(exp_seq[i]));
      next_cycle();
    end
    @(negedge clk);
    chk("drained out_valid", 32'(out_valid), 32'h0);
    chk("drained count", 32'(count), 32'h0);
    next_cycle();
    out_ready = 1'b0;

    // 3: overflow attempt, then clr together with a dropped push
    fill(8'hC0, 4);
    next_cycle();
    in_valid = 1'b1;
    data_in  = 8'h55;
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    chk("ovf set", 32'(ovf_err), 32'h1);
    chk("ovf count", 32'(count), 32'h4);
    chk("ovf head", 32'(data_out), 32'hC0);
    next_cycle();
    clr      = 1'b1;
    in_valid = 1'b1;
    data_in  = 8'h66;
    next_cycle();
    clr      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("clr count", 32'(count), 32'h0);
    chk("clr ovf", 32'(ovf_err), 32'h0);
    chk("clr out_valid", 32'(out_valid), 32'h0);

    // 4: streaming push+pop, pointers wrap twice
    next_cycle();
    in_valid = 1'b1;
    data_in  = 8'h00;
    next_cycle();
    for (int i = 1; i < 10; i++) begin
      in_valid  = 1'b1;
      data_in   = W'(i);
      out_ready = 1'b1;
      @(negedge clk);
      chk("stream data_out", 32'(data_out), 32'(i - 1));
      chk("stream count", 32'(count), 32'h1);
      next_cycle();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream last", 32'(data_out), 32'h09);
    next_cycle();
    out_ready = 1'b0;
    @(negedge clk);
    chk("stream empty", 32'(out_valid), 32'h0);

    // 5: asynchronous reset with three words queued
    fill(8'hE1, 3);
    @(negedge clk);
    chk("pre-reset count", 32'(count), 32'h3);
    #3 rst_n = 1'b0;
    #1;
    chk("async out_valid", 32'(out_valid), 32'h0);
    chk("async count", 32'(count), 32'h0);
    chk("async data_out", 32'(data_out), 32'h5A);
    chk("async in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("post-reset out_valid", 32'(out_valid), 32'h0);
    chk("post-reset data_out", 32'(data_out), 32'h5A);

    // 6: word offered to an empty queue with consumer ready
    next_cycle();
    in_valid  = 1'b1;
    data_in   = 8'hA7;
    out_ready = 1'b1;
    @(negedge clk);
`ifdef VDQ_BYPASS_EN
    chk("bypass data_out", 32'(data_out), 32'hA7);
    chk("bypass out_valid", 32'(out_valid), 32'h1);
`else
    chk("no-bypass data_out", 32'(data_out), 32'h5A);
    chk("no-bypass out_valid", 32'(out_valid), 32'h0);
`endif
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
`ifdef VDQ_BYPASS_EN
    chk("bypass count", 32'(count), 32'h0);
    chk("bypass after", 32'(out_valid), 32'h0);
`else
    chk("latency data_out", 32'(data_out), 32'hA7);
    chk("latency count", 32'(count), 32'h1);
`endif
    next_cycle();
    out_ready = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("final count", 32'(count), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
